parity_frame_rx: RTL and testbench

PARITY_FRAME_RX -- requirements
Module: parity_frame_rx

---
 rtl/parity_frame_rx.sv | 114 +++++++++++
 tb/tb_parity_frame_rx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Forwards payload and raw parity bit to a downstream checker; does not evaluate parity.
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit (0) on a bit_en strobe
// DATA   | shifting in data bits, bit_cnt = index of the next bit
// PARITY | next strobe carries the parity bit
// STOP   | next strobe carries the stop bit; 1 publishes the frame, 0 discards it
module parity_frame_rx #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_out,
    output logic              frame_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [DATA_W-1:0] shift_reg, shift_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              par_bit, par_bit_nxt;
    logic              parity_nxt;
    logic              valid_nxt, err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            par_bit     <= 1'b0;
            data_out    <= '0;
            parity_out  <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift_reg   <= shift_nxt;
            par_bit     <= par_bit_nxt;
            data_out    <= data_nxt;
            parity_out  <= parity_nxt;
            frame_valid <= valid_nxt;
            frame_err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_reg;
        par_bit_nxt = par_bit;
        data_nxt    = data_out;
        parity_nxt  = parity_out;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;

        if (bit_en) begin
            case (state)
                IDLE: begin
                    if (!serial_in) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                        shift_nxt   = '0;
                    end
                end
                DATA: begin
                    // Loop compare avoids indexing with a counter wider than the vector index.
                    for (int i = 0; i < DATA_W; i++) begin
                        if (bit_cnt == CNT_W'(i)) begin
                            shift_nxt[i] = serial_in;
                        end
                    end
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    par_bit_nxt = serial_in;
                    state_nxt   = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (serial_in) begin
                        data_nxt   = shift_reg;
                        parity_nxt = par_bit;
                        valid_nxt  = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: good/bad frames, strobe gaps, back-to-back frames,
// mid-frame reset and idle-line behaviour, with hand-computed expectations.
module tb_parity_frame_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic       bit_en;
    logic [3:0] data_out;
    logic       parity_out;
    logic       frame_valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int idle_hits;
    int v0, e0;

    parity_frame_rx #(.DATA_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .bit_en     (bit_en),
        .data_out   (data_out),
        .parity_out (parity_out),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) valid_cnt++;
        if (frame_err) err_cnt++;
        if (frame_valid && frame_err) both_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobed bit, then 'gap' unstrobed cycles with serial_in toggling as noise.
    task automatic send_bit(input logic b, input int gap);
        serial_in = b;
        bit_en    = 1'b1;
        tick();
        bit_en = 1'b0;
        for (int i = 0; i < gap; i++) begin
            serial_in = ~serial_in;
            tick();
        end
    endtask

    // Everything but the stop bit, so the caller can check the cycle right after it.
    task automatic send_body(input logic [3:0] d, input logic p, input int gap);
        logic [3:0] dv;
        dv = d;
        send_bit(1'b0, gap);
        for (int i = 0; i < 4; i++) send_bit(dv[i], gap);
        send_bit(p, gap);
    endtask

    initial begin
        rst       = 1'b1;
        serial_in = 1'b0;
        bit_en    = 1'b1;
        tick();
        tick();
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_parity", 32'(parity_out), 32'h0);
        chk("rst_valid", 32'(frame_valid), 32'h0);
        chk("rst_err", 32'(frame_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        // Idle line for 20 strobes
        idle_hits = 0;
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b1, 0);
            if (busy || frame_valid || frame_err) idle_hits++;
        end
        chk("idle_quiet", 32'(idle_hits), 32'h0);

        // Good frame 0111 / parity 1
        send_bit(1'b0, 0);
        chk("busy_after_start", 32'(busy), 32'h1);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        chk("busy_before_stop", 32'(busy), 32'h1);
        send_bit(1'b1, 0);
        chk("f1_valid", 32'(frame_valid), 32'h1);
        chk("f1_err", 32'(frame_err), 32'h0);
        chk("f1_data", 32'(data_out), 32'h7);
        chk("f1_parity", 32'(parity_out), 32'h1);
        chk("f1_busy_fall", 32'(busy), 32'h0);
        tick();
        chk("f1_valid_one_cycle", 32'(frame_valid), 32'h0);
        chk("f1_data_hold", 32'(data_out), 32'h7);

        // Bad stop bit: 0001 / parity 0 / stop 0
        send_body(4'b0001, 1'b0, 0);
        send_bit(1'b0, 0);
        chk("f2_err", 32'(frame_err), 32'h1);
        chk("f2_valid", 32'(frame_valid), 32'h0);
        chk("f2_data_kept", 32'(data_out), 32'h7);
        chk("f2_parity_kept", 32'(parity_out), 32'h1);
        tick();
        chk("f2_err_one_cycle", 32'(frame_err), 32'h0);

        // Sparse strobes: every 4th cycle, line toggling in between
        send_body(4'b0011, 1'b0, 3);
        chk("f3_busy_mid", 32'(busy), 32'h1);
        send_bit(1'b1, 0);
        chk("f3_valid", 32'(frame_valid), 32'h1);
        chk("f3_data", 32'(data_out), 32'h3);
        chk("f3_parity", 32'(parity_out), 32'h0);
        tick();

        // Back-to-back frames, no idle bit between them
        v0 = valid_cnt;
        send_body(4'b0001, 1'b1, 0);
        send_bit(1'b1, 0);
        chk("b2b_a_valid", 32'(frame_valid), 32'h1);
        chk("b2b_a_data", 32'(data_out), 32'h1);
        chk("b2b_a_parity", 32'(parity_out), 32'h1);
        send_body(4'b0111, 1'b0, 0);
        send_bit(1'b1, 0);
        chk("b2b_b_valid", 32'(frame_valid), 32'h1);
        chk("b2b_b_data", 32'(data_out), 32'h7);
        chk("b2b_b_parity", 32'(parity_out), 32'h0);
        tick();
        chk("b2b_pulse_count", 32'(valid_cnt - v0), 32'h2);

        // Reset after the second data bit, with a strobe present in the reset cycle
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        rst       = 1'b1;
        serial_in = 1'b0;
        bit_en    = 1'b1;
        tick();
        rst    = 1'b0;
        bit_en = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_data_cleared", 32'(data_out), 32'h0);
        send_body(4'b0000, 1'b0, 0);
        send_bit(1'b1, 0);
        chk("post_abort_valid", 32'(frame_valid), 32'h1);
        chk("post_abort_data", 32'(data_out), 32'h0);
        tick();
        tick();
        chk("abort_valid_count", 32'(valid_cnt - v0), 32'h1);
        chk("abort_err_count", 32'(err_cnt - e0), 32'h0);

        chk("total_valid", 32'(valid_cnt), 32'h5);
        chk("total_err", 32'(err_cnt), 32'h1);
        chk("never_both", 32'(both_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
